// File: rtl/pixel_input_buffer_ng.sv
// First-word-fall-through pixel FIFO between the pixel source and the
// corner/descriptor core, with stall handling, overflow policy and statistics.
module pixel_input_buffer_ng #(
    parameter int LUMA_BITS          = 8,
    parameter int COORD_BITS         = 11,
    parameter int DEPTH              = 2048,
    parameter int OVERFLOW_MODE      = 0,
    parameter int ALMOST_FULL_MARGIN = 16,
    parameter int DROP_COUNT_BITS    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_flush,
    input  logic                       in_valid,
    input  logic [LUMA_BITS-1:0]       in_pixel,
    input  logic [COORD_BITS-1:0]      in_x,
    input  logic [COORD_BITS-1:0]      in_y,
    input  logic                       in_stall,
    output logic                       out_valid,
    output logic [LUMA_BITS-1:0]       out_pixel,
    output logic [COORD_BITS-1:0]      out_x,
    output logic [COORD_BITS-1:0]      out_y,
    output logic                       out_forced,
    output logic [$clog2(DEPTH):0]     out_level,
    output logic                       out_full,
    output logic                       out_almost_full,
    output logic [$clog2(DEPTH):0]     out_high_water,
    output logic [DROP_COUNT_BITS-1:0] out_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = LUMA_BITS + 2 * COORD_BITS;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LEVEL   = LW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [EW-1:0]              mem [DEPTH];
    logic [EW-1:0]              head;
    logic [EW-1:0]              wdata;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [AW-1:0]              rd_next;
    logic [LW-1:0]              level;
    logic [LW-1:0]              level_next;
    logic [LW-1:0]              high_water;
    logic                       full_q;
    logic                       af_q;
    logic [DROP_COUNT_BITS-1:0] drop_cnt;
    logic                       empty;
    logic                       wr;
    logic                       force_pop;
    logic                       pop;
    logic                       push;
    logic                       drop;

    always_comb begin
        wdata      = {in_pixel, in_x, in_y};
        empty      = (level == '0);
        wr         = in_valid && !in_flush;
        force_pop  = (OVERFLOW_MODE == 0) ? (wr && full_q && !empty) : 1'b0;
        pop        = !in_flush && !empty && (!in_stall || force_pop);
        push       = wr && (!full_q || pop);
        drop       = (OVERFLOW_MODE == 1) && wr && full_q && in_stall;
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_next = level + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Head is re-read at the post-pop address every cycle; a write landing
    // on that address is forwarded so back-to-back pops never bubble.
    always_ff @(posedge clk) begin
        if (push && (wr_ptr == rd_next)) begin
            head <= wdata;
        end else begin
            head <= mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || in_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            high_water <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_next;
            level      <= level_next;
            full_q     <= (level_next == FULL_LEVEL);
            af_q       <= (level_next >= AF_LEVEL);
            high_water <= (level > high_water) ? level : high_water;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_COUNT_BITS'(1);
        end
    end

    assign out_valid       = pop;
    assign out_forced      = pop && in_stall;
    assign {out_pixel, out_x, out_y} = head;
    assign out_level       = level;
    assign out_full        = full_q;
    assign out_almost_full = af_q;
    assign out_high_water  = high_water;
    assign out_drop_count  = drop_cnt;

endmodule

// File: tb/tb_pixel_input_buffer_ng.sv
// Directed bench: three buffer instances (drain / drop / deep) share stimulus;
// each scenario checks the instance whose configuration it targets.
module tb_pixel_input_buffer_ng;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic [10:0] in_x = '0;
    logic [10:0] in_y = '0;
    logic        in_stall = 1'b0;

    logic        a_valid, a_forced, a_full, a_af;
    logic [7:0]  a_pixel;
    logic [10:0] a_x, a_y;
    logic [4:0]  a_level, a_hw;
    logic [15:0] a_drop;

    logic        b_valid, b_forced, b_full, b_af;
    logic [7:0]  b_pixel;
    logic [10:0] b_x, b_y;
    logic [4:0]  b_level, b_hw;
    logic [15:0] b_drop;

    logic        c_valid, c_forced, c_full, c_af;
    logic [7:0]  c_pixel;
    logic [10:0] c_x, c_y;
    logic [6:0]  c_level, c_hw;
    logic [15:0] c_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_input_buffer_ng #(
        .DEPTH(16), .OVERFLOW_MODE(0), .ALMOST_FULL_MARGIN(4)
    ) u_a (
        .clk(clk), .reset(reset), .in_flush(in_flush),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x),
        .in_y(in_y), .in_stall(in_stall), .out_valid(a_valid),
        .out_pixel(a_pixel), .out_x(a_x), .out_y(a_y),
        .out_forced(a_forced), .out_level(a_level), .out_full(a_full),
        .out_almost_full(a_af), .out_high_water(a_hw),
        .out_drop_count(a_drop)
    );

    pixel_input_buffer_ng #(
        .DEPTH(16), .OVERFLOW_MODE(1), .ALMOST_FULL_MARGIN(4)
    ) u_b (
        .clk(clk), .reset(reset), .in_flush(in_flush),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x),
        .in_y(in_y), .in_stall(in_stall), .out_valid(b_valid),
        .out_pixel(b_pixel), .out_x(b_x), .out_y(b_y),
        .out_forced(b_forced), .out_level(b_level), .out_full(b_full),
        .out_almost_full(b_af), .out_high_water(b_hw),
        .out_drop_count(b_drop)
    );

    pixel_input_buffer_ng #(
        .DEPTH(64), .OVERFLOW_MODE(0), .ALMOST_FULL_MARGIN(16)
    ) u_c (
        .clk(clk), .reset(reset), .in_flush(in_flush),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x),
        .in_y(in_y), .in_stall(in_stall), .out_valid(c_valid),
        .out_pixel(c_pixel), .out_x(c_x), .out_y(c_y),
        .out_forced(c_forced), .out_level(c_level), .out_full(c_full),
        .out_almost_full(c_af), .out_high_water(c_hw),
        .out_drop_count(c_drop)
    );

    typedef struct {
        bit f;
        bit v;
        int x;
        bit s;
        bit ev;
        int ex;
        int el;
        int ehw;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [7:0] pix_of(input int xv);
        logic [31:0] t;
        t = xv;
        return t[7:0] ^ 8'h5a;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit f, input bit v, input int xv, input bit s);
        @(negedge clk);
        in_flush = f;
        in_valid = v;
        in_x     = 11'(xv);
        in_y     = 11'(xv + 3);
        in_pixel = pix_of(xv);
        in_stall = s;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(bit f, bit v, int x, bit s,
                                bit ev, int ex, int el, int ehw);
        vec_t r;
        r.f = f; r.v = v; r.x = x; r.s = s;
        r.ev = ev; r.ex = ex; r.el = el; r.ehw = ehw;
        return r;
    endfunction

    initial begin
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 1, 1, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 2, 1, 0, 0, 0, 1);
        tbl[5]  = mk(0, 1, 3, 1, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 2, 2, 1);
        tbl[7]  = mk(0, 1, 4, 0, 1, 3, 1, 2);
        tbl[8]  = mk(0, 0, 0, 0, 1, 4, 1, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 2);
        tbl[10] = mk(0, 1, 5, 1, 0, 0, 0, 2);
        tbl[11] = mk(1, 1, 6, 0, 0, 0, 1, 2);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 7, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 7, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1);

        do_reset();
        #1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_level", a_level, 0);
        chk("rst_a_full", a_full, 0);
        chk("rst_a_af", a_af, 0);
        chk("rst_a_hw", a_hw, 0);
        chk("rst_b_drop", b_drop, 0);
        chk("rst_c_level", c_level, 0);

        // table-driven basic sequence on the drain instance
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].f, tbl[i].v, tbl[i].x, tbl[i].s);
            chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_forced", i), a_forced, 0);
            chk($sformatf("tbl%0d_level", i), a_level, tbl[i].el);
            chk($sformatf("tbl%0d_hw", i), a_hw, tbl[i].ehw);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_x", i), a_x, tbl[i].ex);
                chk($sformatf("tbl%0d_pix", i), a_pixel, pix_of(tbl[i].ex));
            end
        end

        // streaming, no stall
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            drive(0, i < 100, i, 0);
            chk("stream_level_le1", a_level <= 1, 1);
            if (i >= 1) begin
                chk("stream_valid", a_valid, 1);
                chk("stream_x", a_x, i - 1);
                chk("stream_y", a_y, i + 2);
            end else begin
                chk("stream_first_valid", a_valid, 0);
            end
        end
        drive(0, 0, 0, 0);
        chk("stream_hw", a_hw, 1);

        // stall then release
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, i, 1);
            chk("stall_valid", a_valid, 0);
        end
        drive(0, 0, 0, 1);
        chk("stall_level", a_level, 10);
        chk("stall_valid_hold", a_valid, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0);
            chk("release_valid", a_valid, 1);
            chk("release_x", a_x, i);
        end
        drive(0, 0, 0, 0);
        chk("release_level", a_level, 0);
        chk("release_hw", a_hw, 10);

        // overflow: force-drain (a) vs drop-newest (b)
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, 1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 16 + k, 1);
            chk("force_full", a_full, 1);
            chk("force_valid", a_valid, 1);
            chk("force_forced", a_forced, 1);
            chk("force_x", a_x, k);
            chk("force_level", a_level, 16);
            chk("drop_valid", b_valid, 0);
            chk("drop_level", b_level, 16);
        end
        drive(0, 0, 0, 1);
        chk("force_level_after", a_level, 16);
        chk("force_drop_cnt", a_drop, 0);
        chk("drop_cnt3", b_drop, 3);
        chk("drop_level_after", b_level, 16);
        for (int i = 0; i < 70000; i++) begin
            drive(0, 1, 1000 + (i % 500), 1);
        end
        drive(0, 0, 0, 1);
        chk("drop_saturate", b_drop, 65535);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0);
            chk("drop_drain_valid", b_valid, 1);
            chk("drop_drain_x", b_x, i);
            chk("drop_drain_forced", b_forced, 0);
        end
        drive(0, 0, 0, 0);
        chk("drop_drain_level", b_level, 0);

        // flush at level 12 with an incoming entry and no stall
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 100 + i, 1);
        end
        drive(1, 1, 200, 0);
        chk("flush_pre_level", b_level, 12);
        chk("flush_valid", b_valid, 0);
        drive(0, 0, 0, 0);
        chk("flush_level", b_level, 0);
        chk("flush_hw", b_hw, 0);
        chk("flush_valid_after", b_valid, 0);
        chk("flush_drop_kept", b_drop, 65535);
        drive(0, 1, 300, 0);
        chk("flush_push_valid", b_valid, 0);
        drive(0, 0, 0, 0);
        chk("flush_pop_valid", b_valid, 1);
        chk("flush_pop_x", b_x, 300);
        chk("flush_pop_level", b_level, 1);

        // almost-full threshold on the deep instance
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive(0, 1, i, 1);
            chk("af_level", c_level, i);
            chk("af_flag", c_af, i >= 48);
        end

        // reset mid-stream at level 40
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, i, 1);
        end
        drive(0, 0, 0, 1);
        chk("pre_reset_level", c_level, 40);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_stall = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_level", c_level, 0);
        chk("mid_rst_valid", c_valid, 0);
        chk("mid_rst_forced", c_forced, 0);
        chk("mid_rst_full", c_full, 0);
        chk("mid_rst_af", c_af, 0);
        chk("mid_rst_hw", c_hw, 0);
        chk("mid_rst_drop", c_drop, 0);
        drive(0, 0, 0, 0);
        chk("post_rst_valid", c_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_input_buffer_ng.md
Name: pixel_input_buffer_ng

Overview:
Next-generation input buffer for the corner/descriptor pipeline, placed between the pixel source and the corner/descriptor core. It holds {pixel, x, y} entries in a parametrised-depth, first-word-fall-through FIFO built on internal RAM. It honours the downstream stall request, and a selectable overflow policy decides what happens when the FIFO is full: force-drain or drop-newest. It also reports occupancy, high-water mark and dropped-pixel count, and supports a single-cycle frame flush.

Parameters:
LUMA_BITS, 8, pixel width
COORD_BITS, 11, width of x and y coordinates
DEPTH, 2048, FIFO entries; power of two, at least 4
OVERFLOW_MODE, 0, 0 = force-drain the head when full and writing; 1 = drop the incoming entry when full and stalled
ALMOST_FULL_MARGIN, 16, out_almost_full asserts when level >= DEPTH-ALMOST_FULL_MARGIN
DROP_COUNT_BITS, 16, width of the saturating drop counter

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high; clears all state
in_flush  in  1  frame flush: empty the FIFO in one cycle
in_valid  in  1  incoming entry valid this cycle
in_pixel  in  LUMA_BITS  incoming luma
in_x, in_y  in  COORD_BITS each  incoming coordinates
in_stall  in  1  downstream stall request (corner/descriptor core busy)
out_valid  out  1  entry transferred downstream this cycle
out_pixel  out  LUMA_BITS  head entry luma
out_x, out_y  out  COORD_BITS each  head entry coordinates
out_forced  out  1  transfer made despite in_stall being high
out_level  out  $clog2(DEPTH)+1  current occupancy
out_full  out  1  level == DEPTH
out_almost_full  out  1  level >= DEPTH-ALMOST_FULL_MARGIN
out_high_water  out  $clog2(DEPTH)+1  maximum level since the last reset or flush
out_drop_count  out  DROP_COUNT_BITS  entries dropped since reset; saturates at all-ones

Behaviour:
- Reset values: out_valid=0, out_forced=0, out_level=0, out_full=0, out_almost_full=0, out_high_water=0, out_drop_count=0. The read and write pointers are 0. out_pixel, out_x and out_y are don't-care while the FIFO is empty.
- Definitions: `empty` = (level==0). `wr` = in_valid && !in_flush.
- `force`:
  - OVERFLOW_MODE=0: force = wr && full && !empty.
  - OVERFLOW_MODE=1: force = 0.
- Pop: pop = !empty && (!in_stall || force). This is combinational.
  - out_valid = pop.
  - out_forced = pop && in_stall.
  - out_pixel, out_x and out_y always show the head entry (first-word fall-through).
- Push:
  - push = wr && (!full || pop).
  - In mode 1, wr && full && in_stall gives drop = 1. The entry is discarded and out_drop_count increments by 1, saturating.
  - In mode 0, drop is always 0.
- No bypass: an entry written into an empty FIFO appears on the head and can be popped at the earliest on the next cycle. Latency from write to out_valid is therefore at least 1 cycle.
- Level update: level += push - pop. A simultaneous push and pop leaves the level unchanged. Pointers wrap modulo DEPTH.
- out_full, out_almost_full and out_level are registered and reflect the state after the update.
- out_high_water updates one cycle after the level is written: high_water <= max(high_water, level).
- Flush: in_flush=1 sets level, both pointers and out_high_water to 0 on the next edge.
  - out_drop_count is retained across a flush.
  - in_valid in the same cycle is ignored and is not counted as dropped.
  - During the flush cycle pop is forced to 0, so out_valid=0.
- Reset has priority over flush. Reset mid-stream discards all contents. The cycle after reset deasserts, out_valid=0.
- Storage is synchronous-read RAM with a registered head. The head register must be re-read after each pop so that back-to-back pops at 1 entry per cycle are sustained with no bubble.
- Throughput: 1 push and 1 pop per cycle simultaneously, at any level.

Test Plan:
- Streaming, in_stall=0: push 100 entries (x=0..99) -> out_valid each cycle starting 1 cycle after the first push; x order is 0..99; out_level never exceeds 1; out_high_water=1.
- Stall then release: DEPTH=16, hold in_stall=1 and push 10 -> out_level=10, out_valid=0. Release in_stall -> 10 consecutive pops in order, out_level reaches 0 and out_high_water=10.
- Force-drain, mode 0: DEPTH=16, fill to 16 with in_stall=1, push 3 more -> 3 pops with out_forced=1 (entries 0,1,2); out_level stays 16; out_drop_count=0.
- Drop, mode 1: same stimulus -> no pops; out_drop_count=3; the final contents are entries 0..15. Repeat the overflow 70000 times with DROP_COUNT_BITS=16 -> out_drop_count=65535.
- Flush: with level=12 and in_valid=1, assert in_flush -> next cycle out_level=0, out_high_water=0, out_valid=0, out_drop_count unchanged. The next push appears on the head and pops 1 cycle later.
- Almost-full and reset: DEPTH=64, margin 16 -> out_almost_full rises exactly when level reaches 48. Assert reset at level 40 -> all outputs take their reset values on the next cycle.
